// File: rtl/psum_pkg.sv
// Shared types and constants for the psum bias/ReLU accumulator.
// Optional saturation is selected with the PSUM_SAT_EN macro.
package psum_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int PIX_W_D  = 36;
    localparam int BIAS_W_D = 16;
    localparam int LANES_D  = 8;
    localparam int CH_W_D   = 10;

    localparam logic [PIX_W_D-1:0] PIX_MAX = {1'b0, {(PIX_W_D-1){1'b1}}};
    localparam logic [PIX_W_D-1:0] PIX_MIN = {1'b1, {(PIX_W_D-1){1'b0}}};

    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/psum_lane.sv
// One lane of the 2-stage partial-sum / bias / ReLU datapath.
// PSUM_SAT_EN selects saturating adds instead of wrap-around.
module psum_lane
    import psum_pkg::*;
#(
    parameter int PIX_W  = PIX_W_D,
    parameter int BIAS_W = BIAS_W_D
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s0_en,
    input  logic              s0_first,
    input  logic              s1_en,
    input  logic              s1_last,
    input  logic [PIX_W-1:0]  psum_new,
    input  logic [PIX_W-1:0]  psum_rd,
    input  logic [BIAS_W-1:0] bias,
    output logic [PIX_W-1:0]  out_data
);

`ifdef PSUM_SAT_EN
    localparam logic [PIX_W-1:0] L_MAX = {1'b0, {(PIX_W-1){1'b1}}};
    localparam logic [PIX_W-1:0] L_MIN = {1'b1, {(PIX_W-1){1'b0}}};

    function automatic logic [PIX_W-1:0] add_w(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b
    );
        logic [PIX_W:0] s;
        s = {a[PIX_W-1], a} + {b[PIX_W-1], b};
        if (s[PIX_W] != s[PIX_W-1])
            return s[PIX_W] ? L_MIN : L_MAX;
        return s[PIX_W-1:0];
    endfunction
`else
    function automatic logic [PIX_W-1:0] add_w(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b
    );
        return a + b;
    endfunction
`endif

    logic [PIX_W-1:0] sum0;
    logic [PIX_W-1:0] bias_ext;
    logic [PIX_W-1:0] s1_sum;
    logic [PIX_W-1:0] s1_bias;
    logic [PIX_W-1:0] b_sum;
    logic [PIX_W-1:0] res;

    assign bias_ext = {{(PIX_W-BIAS_W){bias[BIAS_W-1]}}, bias};

    // Stage-1 merge: first pass takes the new sum, buffer data is stale
    always_comb begin
        sum0 = psum_new;
        if (!s0_first)
            sum0 = add_w(psum_rd, psum_new);
    end

    // Stage-1 registers: merged sum and the bias that travels with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_sum  <= '0;
            s1_bias <= '0;
        end else if (s0_en) begin
            s1_sum  <= sum0;
            s1_bias <= bias_ext;
        end
    end

    // Stage-2 logic: bias add and ReLU only on the final pass
    always_comb begin
        b_sum = add_w(s1_sum, s1_bias);
        res   = s1_sum;
        if (s1_last) begin
            if (b_sum[PIX_W-1] || (b_sum == '0))
                res = '0;
            else
                res = b_sum;
        end
    end

    // Stage-2 register: result presented for write-back
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out_data <= '0;
        else if (s1_en)
            out_data <= res;
    end

endmodule

// File: rtl/psum_bias_relu_array.sv
// Multi-pass partial-sum accumulator with bias/ReLU on the final pass.
// Define PSUM_SAT_EN for saturating arithmetic (default: wrap-around).
module psum_bias_relu_array
    import psum_pkg::*;
#(
    parameter int PIX_W  = PIX_W_D,
    parameter int BIAS_W = BIAS_W_D,
    parameter int LANES  = LANES_D,
    parameter int CH_W   = CH_W_D
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CH_W-1:0]         cfg_last_pass,
    input  logic                    pass_start,
    input  logic                    pass_done,
    input  logic                    in_valid,
    input  logic [LANES*PIX_W-1:0]  psum_new,
    input  logic [LANES*PIX_W-1:0]  psum_rd,
    input  logic [LANES*BIAS_W-1:0] bias,
    output logic                    out_valid,
    output logic [LANES*PIX_W-1:0]  out_data,
    output logic                    out_final,
    output logic [CH_W-1:0]         pass_idx,
    output logic                    idle_o
);

    state_t          state;
    state_t          nxt;
    logic [CH_W-1:0] last_q;
    logic [CH_W-1:0] idx_q;
    logic            drain_q;
    logic            v1;
    logic            l1;
    logic            v2;
    logic            f2;
    logic            s0_en;
    logic            s0_first;
    logic            s0_last;

    assign s0_en     = in_valid && (state == S_RUN);
    assign s0_first  = (idx_q == '0);
    assign s0_last   = (idx_q == last_q);
    assign pass_idx  = idx_q;
    assign out_valid = v2;
    assign out_final = f2;
    assign idle_o    = (state == S_IDLE);

    // Next-state: job start, final pass_done, fixed two-cycle drain
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (pass_start) nxt = S_RUN;
            S_RUN:   if (pass_done && s0_last) nxt = S_DRAIN;
            S_DRAIN: if (drain_q) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // State, pass counter, latched job length and drain timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            state   <= nxt;
            drain_q <= (state == S_DRAIN) ? ~drain_q : 1'b0;
            if ((state == S_IDLE) && pass_start) begin
                idx_q  <= '0;
                last_q <= cfg_last_pass;
            end else if ((state == S_RUN) && pass_done && !s0_last) begin
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

    // Valid and final-pass flags follow the data through both stages
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
            v2 <= 1'b0;
            f2 <= 1'b0;
        end else begin
            v1 <= s0_en;
            l1 <= s0_en && s0_last;
            v2 <= v1;
            f2 <= v1 && l1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int PL = lane_lsb(g, PIX_W);
        localparam int BL = lane_lsb(g, BIAS_W);

        psum_lane #(
            .PIX_W  (PIX_W),
            .BIAS_W (BIAS_W)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .s0_en    (s0_en),
            .s0_first (s0_first),
            .s1_en    (v1),
            .s1_last  (l1),
            .psum_new (psum_new[PL +: PIX_W]),
            .psum_rd  (psum_rd[PL +: PIX_W]),
            .bias     (bias[BL +: BIAS_W]),
            .out_data (out_data[PL +: PIX_W])
        );
    end

endmodule

// File: tb/tb_psum_bias_relu_array.sv
// Directed scoreboard bench for psum_bias_relu_array.
// Expected lane results come from an arithmetic model in this file.
module tb_psum_bias_relu_array;

    localparam int PW = 36;
    localparam int BW = 16;
    localparam int LN = 8;
    localparam int CW = 10;
    localparam int LW = LN * PW;
    localparam longint MAXV = (longint'(1) <<< (PW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (PW - 1));

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CW-1:0] cfg_last_pass;
    logic          pass_start;
    logic          pass_done;
    logic          in_valid;
    logic [LW-1:0] psum_new;
    logic [LW-1:0] psum_rd;
    logic [LN*BW-1:0] bias;
    logic          out_valid;
    logic [LW-1:0] out_data;
    logic          out_final;
    logic [CW-1:0] pass_idx;
    logic          idle_o;

    typedef struct {
        logic [LW-1:0] d;
        logic          f;
        int            c;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    longint nv[LN];
    longint rv[LN];
    longint bv[LN];
    longint mbuf[LN];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     m_pidx = 0;
    int     m_last = 0;
    int     m_st = 0;

    psum_bias_relu_array dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_last_pass (cfg_last_pass),
        .pass_start    (pass_start),
        .pass_done     (pass_done),
        .in_valid      (in_valid),
        .psum_new      (psum_new),
        .psum_rd       (psum_rd),
        .bias          (bias),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_final     (out_final),
        .pass_idx      (pass_idx),
        .idle_o        (idle_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [LW-1:0] o,
                       input logic [LW-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, o, e);
        end
    endtask

    function automatic longint fix(input longint x);
`ifdef PSUM_SAT_EN
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
`else
        logic [PW-1:0] t;
        t = x[PW-1:0];
        return longint'($signed(t));
`endif
    endfunction

    function automatic longint model(input longint n, input longint r,
                                     input longint b);
        longint s;
        if (m_pidx == 0) s = n;
        else s = fix(r + n);
        if (m_pidx == m_last) begin
            s = fix(s + b);
            if (s < 0) s = 0;
        end
        return s;
    endfunction

    // Output side of the scoreboard
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", LW'(out_valid), LW'(0));
            end else begin
                mon_e = q.pop_front();
                chk("data", out_data, mon_e.d);
                chk("final", LW'(out_final), LW'(mon_e.f));
                chk("latency", LW'(cyc - mon_e.c), LW'(2));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        pass_start = 1'b0;
        pass_done  = 1'b0;
    endtask

    task automatic fill(input longint n, input longint b);
        for (int i = 0; i < LN; i++) begin
            nv[i] = n;
            bv[i] = b;
            rv[i] = mbuf[i];
        end
    endtask

    task automatic send();
        exp_t   e;
        longint v;
        e.d = '0;
        for (int i = 0; i < LN; i++) begin
            psum_new[i*PW +: PW] = nv[i][PW-1:0];
            psum_rd[i*PW +: PW]  = rv[i][PW-1:0];
            bias[i*BW +: BW]     = bv[i][BW-1:0];
        end
        in_valid = 1'b1;
        if (m_st == 1) begin
            for (int i = 0; i < LN; i++) begin
                v = model(nv[i], rv[i], bv[i]);
                mbuf[i] = v;
                e.d[i*PW +: PW] = v[PW-1:0];
            end
            e.f = (m_pidx == m_last);
            e.c = cyc;
            q.push_back(e);
        end
    endtask

    task automatic start(input int l);
        cfg_last_pass = CW'(l);
        pass_start = 1'b1;
        m_last = l;
        m_pidx = 0;
        m_st = 1;
    endtask

    task automatic done();
        pass_done = 1'b1;
        if (m_st == 1) begin
            if (m_pidx == m_last) m_st = 2;
            else m_pidx++;
        end
    endtask

    task automatic drain_chk(input string tag);
        done();
        step();
        @(negedge clk);
        chk({tag, "_drain1"}, LW'(idle_o), LW'(0));
        step();
        @(negedge clk);
        chk({tag, "_drain2"}, LW'(idle_o), LW'(0));
        step();
        @(negedge clk);
        chk({tag, "_idle"}, LW'(idle_o), LW'(1));
        m_st = 0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        cfg_last_pass = '0;
        pass_start = 1'b0;
        pass_done = 1'b0;
        in_valid = 1'b0;
        psum_new = '0;
        psum_rd = '0;
        bias = '0;
        for (int i = 0; i < LN; i++) mbuf[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", LW'(out_valid), LW'(0));
        chk("rst_data", out_data, '0);
        chk("rst_final", LW'(out_final), LW'(0));
        chk("rst_idx", LW'(pass_idx), LW'(0));
        chk("rst_idle", LW'(idle_o), LW'(1));
        step();
        reset_n = 1'b1;
        step();

        // in_valid while idle produces nothing
        fill(55, 1);
        send();
        step();
        step();
        step();
        @(negedge clk);
        chk("idle_novalid", LW'(out_valid), LW'(0));

        // single pass: ReLU clamp then positive result
        start(0);
        step();
        @(negedge clk);
        chk("a_busy", LW'(idle_o), LW'(0));
        fill(-5, 3);
        send();
        step();
        fill(10, 3);
        send();
        step();
        step();
        step();
        drain_chk("a");

        // three passes with buffer feedback, cfg changed mid-job
        start(2);
        step();
        cfg_last_pass = '0;
        fill(7, -4);
        rv[0] = 999;
        send();
        step();
        done();
        step();
        fill(7, -4);
        send();
        step();
        done();
        step();
        @(negedge clk);
        chk("b_idx2", LW'(pass_idx), LW'(2));
        fill(7, -4);
        send();
        step();
        step();
        step();
        drain_chk("b");

        // distinct lanes, back-to-back samples, start+done together
        start(1);
        pass_done = 1'b1;
        step();
        @(negedge clk);
        chk("c_start_wins", LW'(pass_idx), LW'(0));
        for (int i = 0; i < LN; i++) begin
            nv[i] = ((i % 2) ? -1 : 1) * (i + 1) * 1000 + i;
            bv[i] = i * 50 - 200;
            rv[i] = i;
        end
        send();
        step();
        for (int i = 0; i < LN; i++) nv[i] = (i + 3) * 111;
        send();
        step();
        done();
        step();
        for (int i = 0; i < LN; i++) begin
            nv[i] = i * 37 - 150;
            bv[i] = 300 - i * 90;
            rv[i] = mbuf[i];
        end
        send();
        step();
        for (int i = 0; i < LN; i++) nv[i] = -i * 500;
        send();
        step();
        step();
        step();
        drain_chk("c");

        // overflow on a middle pass
        start(2);
        step();
        fill(3, 0);
        send();
        step();
        done();
        step();
        fill(1, 0);
        rv[0] = MAXV;
        rv[1] = MINV;
        nv[1] = -1;
        send();
        step();
        done();
        step();
        fill(2, 5);
        send();
        step();
        step();
        step();
        drain_chk("d");

        // pass_done coincident with a pass-0 sample
        start(2);
        step();
        fill(5, 1);
        send();
        done();
        step();
        @(negedge clk);
        chk("f_idx1", LW'(pass_idx), LW'(1));
        fill(6, 1);
        send();
        step();
        done();
        step();
        fill(8, -2);
        send();
        step();
        step();
        step();
        drain_chk("f");

        // reset with samples in flight
        start(0);
        step();
        fill(40, 2);
        send();
        step();
        fill(41, 2);
        send();
        step();
        reset_n = 1'b0;
        q.delete();
        m_st = 0;
        @(negedge clk);
        chk("r_valid", LW'(out_valid), LW'(0));
        chk("r_data", out_data, '0);
        chk("r_idx", LW'(pass_idx), LW'(0));
        chk("r_idle", LW'(idle_o), LW'(1));
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("r_quiet", LW'(out_valid), LW'(0));
        end

        n = 0;
        while (q.size() > 0 && n < 20) begin
            step();
            n++;
        end
        chk("sb_empty", LW'(q.size()), LW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
